// File: rtl/score_seg7_driver_pkg.sv
// rtl/score_seg7_driver_pkg.sv - segment patterns, converter FSM states and BCD helpers
package score_seg7_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_e;

    // Active-low cathodes {dp,g,f,e,d,c,b,a}, dp dark
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [15:0] BCD_MAX = 16'd9999;

    function automatic logic [7:0] seg_pattern(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/score_seg7_driver_bcd.sv
// rtl/score_seg7_driver_bcd.sv - clamped 16-bit binary to 4-digit BCD double-dabble converter
module bin16_to_bcd4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] operand,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd,
    output logic        ovf
);
    import score_seg7_driver_pkg::*;

    conv_state_e r_state;
    logic [15:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_ovf;
    logic        r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_bin   <= 16'd0;
            r_bcd   <= 16'd0;
            r_cnt   <= 4'd0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bin   <= operand;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (r_bin > BCD_MAX) begin
                        r_bin <= BCD_MAX;
                        r_ovf <= 1'b1;
                    end else begin
                        r_ovf <= 1'b0;
                    end
                    r_bcd   <= 16'd0;
                    r_cnt   <= 4'd0;
                    r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {r_bcd, r_bin} <= {bcd_adjust(r_bcd), r_bin} << 1;
                    r_cnt          <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;

endmodule

// File: rtl/score_seg7_driver.sv
// rtl/score_seg7_driver.sv - 4-digit multiplexed score display with paged score select
// SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1 when defined.
module score_seg7_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int PAGE_SCANS  = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic [7:0]  seg
);
    import score_seg7_driver_pkg::*;

    localparam int SW = $clog2(REFRESH_DIV);
    localparam int CW = (PAGE_SCANS > 1) ? $clog2(PAGE_SCANS) : 1;

    logic [SW-1:0] r_slot;
    logic [1:0]    r_digit;
    logic [CW-1:0] r_scan;
    logic [1:0]    r_sel;
    logic          r_sel_chg;
    logic          r_pend;
    logic [15:0]   r_value_q;
    logic [15:0]   r_last;
    logic [15:0]   r_disp;
    logic          r_disp_ovf;
    logic          r_valid;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;

    logic          w_slot_wrap;
    logic          w_scan_wrap;
    logic          w_page_wrap;
    logic [1:0]    w_digit_next;
    logic          w_start;
    logic          w_busy;
    logic          w_done;
    logic [15:0]   w_bcd;
    logic          w_ovf;
    logic [15:0]   w_disp_next;
    logic          w_ovf_next;
    logic          w_valid_next;
    logic [3:0]    w_nib;
    logic          w_lead_zero;
    logic [7:0]    w_seg;

    assign w_slot_wrap  = (r_slot == SW'(REFRESH_DIV - 1));
    assign w_scan_wrap  = w_slot_wrap && (r_digit == 2'd3);
    assign w_page_wrap  = w_scan_wrap && (r_scan == CW'(PAGE_SCANS - 1));
    assign w_digit_next = w_slot_wrap ? r_digit + 2'd1 : r_digit;

    // r_sel_chg also covers reset release, so value_q is refreshed before the first start
    assign w_start = !w_busy && !r_sel_chg && ((r_value_q != r_last) || r_pend);

    bin16_to_bcd4 u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_start),
        .operand (r_value_q),
        .busy    (w_busy),
        .done    (w_done),
        .bcd     (w_bcd),
        .ovf     (w_ovf)
    );

    // seg is built from next-state values so it lines up with the registered anode
    assign w_disp_next  = w_done ? w_bcd : r_disp;
    assign w_ovf_next   = w_done ? w_ovf : r_disp_ovf;
    assign w_valid_next = r_valid || w_done;
    assign w_nib        = w_disp_next[{w_digit_next, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign w_lead_zero = (w_digit_next != 2'd0) &&
                         ((w_disp_next >> {w_digit_next, 2'b00}) == 16'd0);
`else
    assign w_lead_zero = 1'b0;
`endif

    always_comb begin
        w_seg = SEG_BLANK;
        if (w_valid_next && !w_lead_zero) begin
            w_seg = seg_pattern(w_nib);
            if (w_digit_next == 2'd0 && w_ovf_next) begin
                w_seg[7] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot     <= '0;
            r_digit    <= 2'd0;
            r_scan     <= '0;
            r_sel      <= 2'd0;
            r_sel_chg  <= 1'b1;
            r_pend     <= 1'b0;
            r_value_q  <= 16'd0;
            r_last     <= 16'hFFFF;
            r_disp     <= 16'd0;
            r_disp_ovf <= 1'b0;
            r_valid    <= 1'b0;
            r_an       <= 4'b1111;
            r_seg      <= SEG_BLANK;
        end else begin
            r_slot  <= w_slot_wrap ? '0 : r_slot + 1'b1;
            r_digit <= w_digit_next;
            if (w_scan_wrap) begin
                r_scan <= w_page_wrap ? '0 : r_scan + 1'b1;
            end
            if (w_page_wrap) begin
                r_sel <= r_sel + 2'd1;
            end
            r_sel_chg <= w_page_wrap;
            if (!w_busy || r_sel_chg) begin
                r_value_q <= value;
            end
            if (r_sel_chg) begin
                r_pend <= 1'b1;
            end else if (w_start) begin
                r_pend <= 1'b0;
            end
            if (w_start) begin
                r_last <= r_value_q;
            end
            r_disp     <= w_disp_next;
            r_disp_ovf <= w_ovf_next;
            r_valid    <= w_valid_next;
            r_an       <= ~(4'b0001 << w_digit_next);
            r_seg      <= w_seg;
        end
    end

    assign sel = r_sel;
    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_score_seg7_driver.sv
// tb/tb_score_seg7_driver.sv - self-checking bench for score_seg7_driver with a paged score mux model
module tb_score_seg7_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] imux [4];

    int total = 0;
    int bad   = 0;
    int k     = 0;

    always #5 clk = ~clk;

    assign value = imux[sel];

    // k = rising edges since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    score_seg7_driver #(.REFRESH_DIV(4), .PAGE_SCANS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .sel   (sel),
        .an    (an),
        .seg   (seg)
    );

    function automatic logic [7:0] exp_seg(input int n, input int d);
        int v, p, dig;
        logic [7:0] s;
        v = (n > 9999) ? 9999 : n;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        dig = (v / p) % 10;
        case (dig)
            0: s = 8'hC0;
            1: s = 8'hF9;
            2: s = 8'hA4;
            3: s = 8'hB0;
            4: s = 8'h99;
            5: s = 8'h92;
            6: s = 8'h82;
            7: s = 8'hF8;
            8: s = 8'h80;
            default: s = 8'h90;
        endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d > 0 && v < p) s = 8'hFF;
`endif
        if (d == 0 && n > 9999) s[7] = 1'b0;
        return s;
    endfunction

    function automatic logic [3:0] exp_an(input int kk);
        logic [3:0] a;
        a = ~(4'b0001 << ((kk / 4) % 4));
        return a;
    endfunction

    function automatic logic [1:0] exp_sel(input int kk);
        return 2'((kk / 32) % 4);
    endfunction

    task automatic wait_k(input int target);
        int guard;
        guard = 0;
        while (k < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (k != target) begin
            total++;
            bad++;
            $display("FAIL wait_k reached=%0d wanted=%0d", k, target);
        end
    endtask

    task automatic check_window(input int n, input string tag);
        int d;
        logic [7:0] e;
        total++;
        if (sel !== exp_sel(k)) begin
            bad++;
            $display("FAIL %s_sel k=%0d got=%0d want=%0d", tag, k, sel, exp_sel(k));
        end
        for (int i = 0; i < 16; i++) begin
            d = (k / 4) % 4;
            e = exp_seg(n, d);
            total++;
            if (an !== exp_an(k)) begin
                bad++;
                $display("FAIL %s_an k=%0d got=%b want=%b", tag, k, an, exp_an(k));
            end
            total++;
            if (seg !== e) begin
                bad++;
                $display("FAIL %s_seg k=%0d digit=%0d got=%h want=%h", tag, k, d, seg, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_async_reset(input string tag);
        total++;
        if (an !== 4'b1111) begin bad++; $display("FAIL %s_an got=%b want=1111", tag, an); end
        total++;
        if (seg !== 8'hFF) begin bad++; $display("FAIL %s_seg got=%h want=ff", tag, seg); end
        total++;
        if (sel !== 2'd0) begin bad++; $display("FAIL %s_sel got=%0d want=0", tag, sel); end
    endtask

    task automatic check_startup(input string tag);
        for (int t = 1; t < 24; t++) begin
            @(negedge clk);
            total++;
            if (an !== exp_an(k)) begin
                bad++;
                $display("FAIL %s_an k=%0d got=%b want=%b", tag, k, an, exp_an(k));
            end
            total++;
            if (sel !== exp_sel(k)) begin
                bad++;
                $display("FAIL %s_sel k=%0d got=%0d want=%0d", tag, k, sel, exp_sel(k));
            end
            if (k <= 18) begin
                total++;
                if (seg !== 8'hFF) begin
                    bad++;
                    $display("FAIL %s_blank k=%0d got=%h want=ff", tag, k, seg);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_async_reset("reset");
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        check_startup("scan");
    endtask

    task automatic test_pages();
        for (int s = 0; s < 5; s++) begin
            wait_k(32 * s + 24);
            check_window(int'(imux[s % 4]), $sformatf("page%0d", s));
        end
    endtask

    task automatic test_clamp();
        int big;
        big = 10000 + int'($urandom_range(0, 55535));
        wait_k(168);
        imux[0] = 16'(big);
        wait_k(256 + 24);
        check_window(big, "clamp_ovf");
        wait_k(300);
        imux[0] = 16'd9999;
        wait_k(384 + 24);
        check_window(9999, "clamp_max");
    endtask

    task automatic test_mid_change();
        int p, d, rel;
        logic [7:0] e_old, e_a, e_b;
        p = 512;
        wait_k(430);
        imux[0] = 16'd200;
        wait_k(p + 7);
        imux[0] = 16'd4321;
        for (int kk = p + 7; kk <= p + 57; kk++) begin
            d     = (k / 4) % 4;
            rel   = k - p;
            e_old = exp_seg(int'(imux[3]), d);
            e_a   = exp_seg(200, d);
            e_b   = exp_seg(4321, d);
            total++;
            if (seg !== e_old && seg !== e_a && seg !== e_b) begin
                bad++;
                $display("FAIL mid_intermediate k=%0d digit=%0d got=%h", k, d, seg);
            end
            if (rel >= 22 && rel <= 37) begin
                total++;
                if (seg !== e_a) begin
                    bad++;
                    $display("FAIL mid_first k=%0d digit=%0d got=%h want=%h", k, d, seg, e_a);
                end
            end
            if (rel >= 42 && rel <= 57) begin
                total++;
                if (seg !== e_b) begin
                    bad++;
                    $display("FAIL mid_second k=%0d digit=%0d got=%h want=%h", k, d, seg, e_b);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midshift();
        wait_k(580);
        imux[0] = 16'd200;
        wait_k(640 + 8);
        rst_n = 1'b0;
        #1;
        check_async_reset("rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_startup("rst_mid_after");
        wait_k(24);
        check_window(200, "rst_mid_disp");
    endtask

    initial begin
        imux[0] = 16'd200;
        imux[1] = 16'd100;
        imux[2] = 16'd0;
        imux[3] = 16'd150;
        test_reset();
        test_scan();
        test_pages();
        test_clamp();
        test_mid_change();
        test_reset_midshift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog k=%0d", k);
        $fatal(1, "timeout");
    end

endmodule
